// File: rtl/sap_1_controller_sequencer_pkg.sv
// Shared SAP-1 definitions: opcodes, T-state one-hot codes, control word layout
// and the control-word decode used by the controller-sequencer.
package sap_1_controller_sequencer_pkg;

    localparam int unsigned OPCODE_BITS = 4;
    localparam int unsigned T_W         = 6;
    localparam int unsigned CW_W        = 12;

    localparam logic [OPCODE_BITS-1:0] OP_LDA = 4'b0000;
    localparam logic [OPCODE_BITS-1:0] OP_ADD = 4'b0001;
    localparam logic [OPCODE_BITS-1:0] OP_SUB = 4'b0010;
    localparam logic [OPCODE_BITS-1:0] OP_OUT = 4'b1110;
    localparam logic [OPCODE_BITS-1:0] OP_HLT = 4'b1111;

    // One-hot ring states; bit 0 is T1
    typedef enum logic [T_W-1:0] {
        T1 = 6'b000001,
        T2 = 6'b000010,
        T3 = 6'b000100,
        T4 = 6'b001000,
        T5 = 6'b010000,
        T6 = 6'b100000
    } t_state_e;

    // Control word, Cp in the MSB down to Lo in the LSB
    typedef struct packed {
        logic cp;
        logic ep;
        logic lm;
        logic ce;
        logic li;
        logic ei;
        logic la;
        logic ea;
        logic su;
        logic eu;
        logic lb;
        logic lo;
    } ctrl_word_t;

    localparam ctrl_word_t CW_RESET = '{ep: 1'b1, lm: 1'b1, default: 1'b0};

    // Control word for a given ring state and opcode (HLT handled by caller)
    function automatic ctrl_word_t decode_cw(input t_state_e t, input logic [OPCODE_BITS-1:0] op);
        ctrl_word_t cw;
        cw = '0;
        case (t)
            T1: begin cw.ep = 1'b1; cw.lm = 1'b1; end
            T2: cw.cp = 1'b1;
            T3: begin cw.ce = 1'b1; cw.li = 1'b1; end
            T4: begin
                if (op == OP_LDA || op == OP_ADD || op == OP_SUB) begin
                    cw.ei = 1'b1; cw.lm = 1'b1;
                end else if (op == OP_OUT) begin
                    cw.ea = 1'b1; cw.lo = 1'b1;
                end
            end
            T5: begin
                if (op == OP_LDA) begin
                    cw.ce = 1'b1; cw.la = 1'b1;
                end else if (op == OP_ADD || op == OP_SUB) begin
                    cw.ce = 1'b1; cw.lb = 1'b1;
                end
            end
            T6: begin
                if (op == OP_ADD) begin
                    cw.eu = 1'b1; cw.la = 1'b1;
                end else if (op == OP_SUB) begin
                    cw.su = 1'b1; cw.eu = 1'b1; cw.la = 1'b1;
                end
            end
            default: cw = '0;
        endcase
        return cw;
    endfunction

endpackage

// File: rtl/sap_1_ring_counter.sv
// Six-state one-hot ring counter stepping on the falling clock edge.
// Ports: clk, rst_n (async active-low, clears to T1), hold (freeze),
//        t_q (current state), t_d_c (next state, combinational).
module sap_1_ring_counter
    import sap_1_controller_sequencer_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  logic     hold,
    output t_state_e t_q,
    output t_state_e t_d_c
);

    t_state_e t_d;

    // Next state: rotate unless held; any illegal code recovers to T1
    always_comb begin
        t_d = t_q;
        if (!hold) begin
            case (t_q)
                T1:      t_d = T2;
                T2:      t_d = T3;
                T3:      t_d = T4;
                T4:      t_d = T5;
                T5:      t_d = T6;
                T6:      t_d = T1;
                default: t_d = T1;
            endcase
        end
    end

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t_q <= T1;
        end else begin
            t_q <= t_d;
        end
    end

    assign t_d_c = t_d;

endmodule

// File: rtl/sap_1_controller_sequencer.sv
// SAP-1 controller-sequencer: ring counter plus opcode decode into a
// registered 12-bit control word and halt flag, all updated on falling Clk.
// Ports: Clk, ClrN (async active-low), Opcode; outputs Clr (= !ClrN),
//        Cp Ep Lm CE Li Ei La Ea Su Eu Lb Lo, Hlt, T (one-hot, T[0] = T1).
module sap_1_controller_sequencer
    import sap_1_controller_sequencer_pkg::*;
#(
    parameter int unsigned OPCODE_W = 4
) (
    input  logic                Clk,
    input  logic                ClrN,
    input  logic [OPCODE_W-1:0] Opcode,
    output logic                Clr,
    output logic                Cp,
    output logic                Ep,
    output logic                Lm,
    output logic                CE,
    output logic                Li,
    output logic                Ei,
    output logic                La,
    output logic                Ea,
    output logic                Su,
    output logic                Eu,
    output logic                Lb,
    output logic                Lo,
    output logic                Hlt,
    output logic [T_W-1:0]      T
);

    t_state_e                  t_q;
    t_state_e                  t_next_c;
    ctrl_word_t                cw_q;
    ctrl_word_t                cw_d;
    logic                      hlt_q;
    logic                      hlt_d;
    logic [OPCODE_BITS-1:0]    op_c;

    assign op_c = OPCODE_BITS'(Opcode);

    sap_1_ring_counter u_ring (
        .clk   (Clk),
        .rst_n (ClrN),
        .hold  (hlt_q),
        .t_q   (t_q),
        .t_d_c (t_next_c)
    );

    // Decode from the next state so the word changes together with T
    always_comb begin
        cw_d  = decode_cw(t_next_c, op_c);
        hlt_d = 1'b0;
        if (hlt_q || (t_next_c == T4 && op_c == OP_HLT)) begin
            cw_d  = '0;
            hlt_d = 1'b1;
        end
    end

    always_ff @(negedge Clk or negedge ClrN) begin
        if (!ClrN) begin
            cw_q  <= CW_RESET;
            hlt_q <= 1'b0;
        end else begin
            cw_q  <= cw_d;
            hlt_q <= hlt_d;
        end
    end

    assign Clr = !ClrN;
    assign Cp  = cw_q.cp;
    assign Ep  = cw_q.ep;
    assign Lm  = cw_q.lm;
    assign CE  = cw_q.ce;
    assign Li  = cw_q.li;
    assign Ei  = cw_q.ei;
    assign La  = cw_q.la;
    assign Ea  = cw_q.ea;
    assign Su  = cw_q.su;
    assign Eu  = cw_q.eu;
    assign Lb  = cw_q.lb;
    assign Lo  = cw_q.lo;
    assign Hlt = hlt_q;
    assign T   = t_q;

endmodule

// File: tb/tb_sap_1_controller_sequencer.sv
// Directed bench for the SAP-1 controller-sequencer.
module tb_sap_1_controller_sequencer;

    logic       Clk;
    logic       ClrN;
    logic [3:0] Opcode;
    logic       Clr, Cp, Ep, Lm, CE, Li, Ei, La, Ea, Su, Eu, Lb, Lo, Hlt;
    logic [5:0] T;
    logic [11:0] cw_obs;

    int total = 0;
    int bad   = 0;

    // Expected control words, bit order Cp Ep Lm CE Li Ei La Ea Su Eu Lb Lo
    localparam logic [11:0] W_NONE  = 12'h000;
    localparam logic [11:0] W_EPLM  = 12'h600;
    localparam logic [11:0] W_CP    = 12'h800;
    localparam logic [11:0] W_CELI  = 12'h180;
    localparam logic [11:0] W_EILM  = 12'h240;
    localparam logic [11:0] W_CELA  = 12'h120;
    localparam logic [11:0] W_CELB  = 12'h102;
    localparam logic [11:0] W_EULA  = 12'h024;
    localparam logic [11:0] W_SUEULA = 12'h02C;
    localparam logic [11:0] W_EALO  = 12'h011;

    localparam logic [5:0] S1 = 6'b000001;
    localparam logic [5:0] S2 = 6'b000010;
    localparam logic [5:0] S3 = 6'b000100;
    localparam logic [5:0] S4 = 6'b001000;
    localparam logic [5:0] S5 = 6'b010000;
    localparam logic [5:0] S6 = 6'b100000;

    sap_1_controller_sequencer #(.OPCODE_W(4)) dut (
        .Clk(Clk), .ClrN(ClrN), .Opcode(Opcode), .Clr(Clr),
        .Cp(Cp), .Ep(Ep), .Lm(Lm), .CE(CE), .Li(Li), .Ei(Ei),
        .La(La), .Ea(Ea), .Su(Su), .Eu(Eu), .Lb(Lb), .Lo(Lo),
        .Hlt(Hlt), .T(T)
    );

    assign cw_obs = {Cp, Ep, Lm, CE, Li, Ei, La, Ea, Su, Eu, Lb, Lo};

    initial Clk = 1'b1;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [5:0] t_e, input logic [11:0] w_e,
                       input logic h_e, input logic c_e);
        logic [19:0] obs;
        logic [19:0] exp;
        obs = {T, cw_obs, Hlt, Clr};
        exp = {t_e, w_e, h_e, c_e};
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed T=%b w=%h hlt=%b clr=%b expected T=%b w=%h hlt=%b clr=%b",
                   tag, obs[19:14], obs[13:2], obs[1], obs[0],
                   exp[19:14], exp[13:2], exp[1], exp[0]);
        end
    endtask

    // Advance one falling edge and settle
    task automatic step();
        @(negedge Clk);
        #2;
    endtask

    // One full instruction starting at T1; optionally scramble Opcode during fetch
    task automatic instr(input string name, input logic [3:0] op, input logic [11:0] w4,
                         input logic [11:0] w5, input logic [11:0] w6, input bit scramble);
        Opcode = scramble ? 4'($urandom) : op;
        step(); chk({name, "_t2"}, S2, W_CP, 1'b0, 1'b0);
        if (scramble) Opcode = 4'($urandom);
        step(); chk({name, "_t3"}, S3, W_CELI, 1'b0, 1'b0);
        Opcode = op;
        step(); chk({name, "_t4"}, S4, w4, 1'b0, 1'b0);
        step(); chk({name, "_t5"}, S5, w5, 1'b0, 1'b0);
        step(); chk({name, "_t6"}, S6, w6, 1'b0, 1'b0);
        step(); chk({name, "_t1"}, S1, W_EPLM, 1'b0, 1'b0);
    endtask

    initial begin
        logic [4:0] bus;
        int idx;
        ClrN   = 1'b0;
        Opcode = 4'b0000;
        #12;
        chk("reset", S1, W_EPLM, 1'b0, 1'b1);
        ClrN = 1'b1;
        step(); chk("first_edge", S2, W_CP, 1'b0, 1'b0);

        // Finish the LDA whose fetch started out of reset
        step(); chk("lda_t3", S3, W_CELI, 1'b0, 1'b0);
        step(); chk("lda_t4", S4, W_EILM, 1'b0, 1'b0);
        step(); chk("lda_t5", S5, W_CELA, 1'b0, 1'b0);
        step(); chk("lda_t6", S6, W_NONE, 1'b0, 1'b0);
        step(); chk("lda_t1", S1, W_EPLM, 1'b0, 1'b0);

        instr("add", 4'b0001, W_EILM, W_CELB, W_EULA, 1'b0);
        instr("sub", 4'b0010, W_EILM, W_CELB, W_SUEULA, 1'b0);
        instr("out", 4'b1110, W_EALO, W_NONE, W_NONE, 1'b0);
        instr("nop", 4'b0101, W_NONE, W_NONE, W_NONE, 1'b1);
        instr("lda_scr", 4'b0000, W_EILM, W_CELA, W_NONE, 1'b1);
        instr("sub_scr", 4'b0010, W_EILM, W_CELB, W_SUEULA, 1'b1);

        // Abort mid-instruction at T5
        Opcode = 4'b0001;
        step(); step(); step();
        step(); chk("abort_pre", S5, W_CELB, 1'b0, 1'b0);
        #1 ClrN = 1'b0;
        #1 chk("abort_imm", S1, W_EPLM, 1'b0, 1'b1);
        step(); chk("abort_held", S1, W_EPLM, 1'b0, 1'b1);
        ClrN = 1'b1;
        step(); chk("abort_rel", S2, W_CP, 1'b0, 1'b0);

        // Halt
        step(); chk("hlt_t3", S3, W_CELI, 1'b0, 1'b0);
        Opcode = 4'b1111;
        step(); chk("hlt_t4", S4, W_NONE, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) begin
            if (i == 10) Opcode = 4'b0000;
            step(); chk("hlt_hold", S4, W_NONE, 1'b1, 1'b0);
        end
        #1 ClrN = 1'b0;
        #1 chk("hlt_exit", S1, W_EPLM, 1'b0, 1'b1);
        #2 ClrN = 1'b1;
        step(); chk("hlt_rel", S2, W_CP, 1'b0, 1'b0);

        // Random opcodes (excluding HLT): ring advances and one bus driver at most
        idx = 1;
        for (int i = 0; i < 1000; i++) begin
            Opcode = 4'($urandom_range(0, 14));
            @(negedge Clk);
            idx = (idx + 1) % 6;
            @(posedge Clk);
            #1;
            bus = {Ep, CE, Ei, Ea, Eu};
            total++;
            assert ($countones(bus) <= 1) else begin
                bad++;
                $error("FAIL bus_excl: observed drivers=%b expected at most one", bus);
            end
            total++;
            assert (T === 6'(1 << idx)) else begin
                bad++;
                $error("FAIL ring_rand: observed T=%b expected T=%b", T, 6'(1 << idx));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
